wb_bus_switch_nxm: RTL

//  Parametrised Wishbone classic interconnect: NUM_MASTERS masters to NUM_SLAVES slaves, replacing

---
 rtl/wb_switch_pkg.sv | 30 +++
 rtl/wb_rr_arbiter.sv | 30 +++
 rtl/wb_bus_switch_nxm.sv | 138 +++++++++++++
 3 files changed

// File: rtl/wb_switch_pkg.sv
// Shared types, bus widths and elaboration-time helpers for the Wishbone N x M switch.
package wb_switch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam int SEL_W = 4;

  // Index width that never collapses to zero bits, so a single master still gets a 1-bit index.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  // Default slave map: slave i occupies the 4 KiB page starting at i << 12.
  function automatic logic [16*32-1:0] default_bases();
    logic [16*32-1:0] b;
    b = '0;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = 32'(i) << 12;
    return b;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester after 'last' (with wrap-around) wins.
module wb_rr_arbiter
  import wb_switch_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int IW          = clog2_min1(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IW-1:0]          last,
  output logic [IW-1:0]          grant_idx,
  output logic                   grant_valid
);

  logic [IW-1:0] idx;

  // Scan from the farthest offset down to the nearest, so the nearest requester is written last.
  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      idx = IW'((int'(last) + i) % NUM_MASTERS);
      if (req[idx]) begin
        grant_idx   = idx;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_bus_switch_nxm.sv
// Wishbone classic N-master x M-slave switch: round-robin grant, base/mask decode,
// registered one-cycle ack/err, error on decode miss or slave timeout.
module wb_bus_switch_nxm
  import wb_switch_pkg::*;
#(
  parameter int                        NUM_MASTERS    = 2,
  parameter int                        NUM_SLAVES     = 8,
  parameter logic [NUM_SLAVES*32-1:0]  SLAVE_BASE     = (NUM_SLAVES*32)'(default_bases()),
  parameter logic [NUM_SLAVES*32-1:0]  SLAVE_MASK     = {NUM_SLAVES{32'hFFFF_F000}},
  parameter int                        TIMEOUT_CYCLES = 255
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_MASTERS-1:0]        m_stb_i,
  input  logic [NUM_MASTERS-1:0]        m_we_i,
  input  logic [NUM_MASTERS*ADR_W-1:0]  m_adr_i,
  input  logic [NUM_MASTERS*DAT_W-1:0]  m_dat_i,
  input  logic [NUM_MASTERS*SEL_W-1:0]  m_sel_i,
  output logic [DAT_W-1:0]              m_dat_o,
  output logic [NUM_MASTERS-1:0]        m_ack_o,
  output logic [NUM_MASTERS-1:0]        m_err_o,
  output logic [NUM_SLAVES-1:0]         s_cyc_o,
  output logic [NUM_SLAVES-1:0]         s_stb_o,
  output logic                          s_we_o,
  output logic [ADR_W-1:0]              s_adr_o,
  output logic [DAT_W-1:0]              s_dat_o,
  output logic [SEL_W-1:0]              s_sel_o,
  input  logic [NUM_SLAVES*DAT_W-1:0]   s_dat_i,
  input  logic [NUM_SLAVES-1:0]         s_ack_i,
  output logic [1:0]                    dbg_state
);

  localparam int IW = clog2_min1(NUM_MASTERS);
  localparam int SW = clog2_min1(NUM_SLAVES);

  // Handshake: a master holds stb until it sees its one-cycle ack or err; a slave is strobed
  // only while BUSY and its ack is taken on the first edge it is seen high.
  state_t               state, state_nxt;
  logic [IW-1:0]        rr_last, grant, arb_idx;
  logic                 arb_valid;
  logic [NUM_SLAVES-1:0] sel_onehot;
  logic                 hit;
  logic [SW-1:0]        hit_idx;
  logic [31:0]          tmo_cnt;
  logic                 tmo_fire, slave_ack;
  logic [DAT_W-1:0]     slave_rdata;

  wb_rr_arbiter #(.NUM_MASTERS(NUM_MASTERS), .IW(IW)) u_arb (
    .req         (m_stb_i),
    .last        (rr_last),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  // Decode runs on the latched address; a miss spends its one BUSY cycle with no strobe,
  // which keeps the error on the same cycle an ack from a zero-wait slave would arrive.
  always_comb begin
    sel_onehot = '0;
    hit        = 1'b0;
    hit_idx    = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((s_adr_o & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
        sel_onehot    = '0;
        sel_onehot[i] = 1'b1;
        hit           = 1'b1;
        hit_idx       = SW'(i);
      end
    end
  end

  assign slave_ack   = hit && s_ack_i[hit_idx];
  assign slave_rdata = s_dat_i[DAT_W*int'(hit_idx) +: DAT_W];
  assign tmo_fire    = (TIMEOUT_CYCLES != 0) && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign s_stb_o     = (state == BUSY) ? sel_onehot : '0;
  assign s_cyc_o     = s_stb_o;
  assign dbg_state   = state;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arb_valid) state_nxt = BUSY;
      BUSY:    if (!hit || slave_ack || tmo_fire) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_last <= IW'(NUM_MASTERS - 1);
      grant   <= '0;
      s_we_o  <= 1'b0;
      s_adr_o <= '0;
      s_dat_o <= '0;
      s_sel_o <= '0;
      m_dat_o <= '0;
      m_ack_o <= '0;
      m_err_o <= '0;
      tmo_cnt <= '0;
    end else begin
      m_ack_o <= '0;
      m_err_o <= '0;
      case (state)
        IDLE: begin
          if (arb_valid) begin
            grant   <= arb_idx;
            s_we_o  <= m_we_i[arb_idx];
            s_adr_o <= m_adr_i[ADR_W*int'(arb_idx) +: ADR_W];
            s_dat_o <= m_dat_i[DAT_W*int'(arb_idx) +: DAT_W];
            s_sel_o <= m_sel_i[SEL_W*int'(arb_idx) +: SEL_W];
            tmo_cnt <= '0;
          end
        end
        BUSY: begin
          tmo_cnt <= tmo_cnt + 32'd1;
          if (!hit) begin
            m_err_o[grant] <= 1'b1;
            m_dat_o        <= '0;
          end else if (slave_ack) begin
            m_ack_o[grant] <= 1'b1;
            m_dat_o        <= s_we_o ? '0 : slave_rdata;
          end else if (tmo_fire) begin
            m_err_o[grant] <= 1'b1;
            m_dat_o        <= '0;
          end
        end
        RESP:    rr_last <= grant;
        default: ;
      endcase
    end
  end

endmodule
